// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin bridge from NUM_REQ simple req/we/addr/data requesters onto one AXI4-Lite master port, one txn in flight.
// Latency: grant at T, AW/W or AR at T+1, B/R ready at T+2, done pulse at T+3 with a zero-wait slave.
// Backpressure: valids hold until their handshake; requesters hold req until done; no new grant while busy or in DONE.
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        done,
  output logic [31:0]               rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [31:0]               m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_nxt;
  logic               pick_vld;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_wstrb;
  logic               aw_ok;
  logic               w_ok;

  // Round-robin search: first requesting index at or after the pointer, wrapping.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_sel;
    idx      = 0;
    idx_sel  = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_sel = IDX_W'(idx);
      if (!pick_vld && req[idx_sel]) begin
        pick_vld = 1'b1;
        pick_idx = idx_sel;
      end
    end
    ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  end

  // Select the command fields of the requester picked above.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_wstrb = req_wstrb[i*4 +: 4];
      end
    end
  end

  // A write channel is finished once its valid has dropped or it handshakes this cycle.
  assign aw_ok = !m_awvalid || m_awready;
  assign w_ok  = !m_wvalid  || m_wready;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded handshake/completion outputs.
  always_comb begin
    state_nxt = state;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    done      = '0;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = sel_we ? S_WADDR : S_RADDR;
      S_WADDR: if (aw_ok && w_ok) state_nxt = S_WRESP;
      S_WRESP: begin
        m_bready = 1'b1;
        if (m_bvalid) state_nxt = S_DONE;
      end
      S_RADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = S_RDATA;
      end
      S_RDATA: begin
        m_rready = 1'b1;
        if (m_rvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        done[grant_idx] = 1'b1;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant capture, independent AW/W valids, and response latching.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_araddr  <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            rr_ptr    <= ptr_nxt;
            if (sel_we) begin
              m_awaddr  <= sel_addr;
              m_wdata   <= sel_wdata;
              m_wstrb   <= sel_wstrb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
            end else begin
              m_araddr  <= sel_addr;
            end
          end
        end
        S_WADDR: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
        end
        S_WRESP: begin
          if (m_bvalid) begin
            rsp_resp  <= m_bresp;
            rsp_rdata <= '0;
          end
        end
        S_RDATA: begin
          if (m_rvalid) begin
            rsp_resp  <= m_rresp;
            rsp_rdata <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter with a small AXI4-Lite slave model.
// Latency: checks cycle-exact timing of grant, channel valids/readies and done.
// Backpressure: slave can stall W by a programmable count and withhold R.
module tb_axi4_lite_req_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  done;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_req_arbiter #(.NUM_REQ(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .done(done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model state
  logic [31:0] mem [0:15];
  logic        aw_got, w_got, ar_got;
  logic [31:0] aw_a, ar_a, wd;
  logic [3:0]  ws;
  int          wcount;
  int          w_dly_cfg = 0;
  logic        r_hold    = 1'b0;
  int          aw_cnt    = 0;
  int          w_cnt     = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Slave: sample handshakes at the edge, update its outputs 1 time unit later.
  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] c_awaddr, c_wdata, c_araddr;
    logic [3:0]  c_wstrb;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    aw_got = 0; w_got = 0; ar_got = 0; aw_a = 0; ar_a = 0; wd = 0; ws = 0; wcount = 0;
    forever begin
      @(posedge clk);
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      c_awaddr = m_awaddr; c_wdata = m_wdata; c_wstrb = m_wstrb; c_araddr = m_araddr;
      #1;
      if (!reset) begin
        aw_got = 0; w_got = 0; ar_got = 0; wcount = 0;
        m_bvalid = 1'b0; m_rvalid = 1'b0;
      end else begin
        if (b_hs) begin
          m_bvalid = 1'b0; aw_got = 0; w_got = 0; wcount = 0;
        end
        if (aw_hs) begin
          aw_got = 1; aw_a = c_awaddr; aw_cnt++; wcount = 1;
        end else if (aw_got && !w_got && !w_hs) begin
          wcount++;
        end
        if (w_hs) begin
          w_got = 1; wd = c_wdata; ws = c_wstrb; w_cnt++;
        end
        if (aw_got && w_got && !m_bvalid) begin
          m_bvalid = 1'b1;
          if (aw_a == 32'd50) begin
            m_bresp = 2'b10;
          end else begin
            m_bresp = 2'b00;
            for (int b = 0; b < 4; b++)
              if (ws[b]) mem[aw_a[5:2]][8*b +: 8] = wd[8*b +: 8];
          end
        end
        if (r_hs) begin
          m_rvalid = 1'b0; ar_got = 0;
        end
        if (ar_hs) begin
          ar_got = 1; ar_a = c_araddr;
        end
        if (ar_got && !m_rvalid && !r_hold) begin
          m_rvalid = 1'b1;
          if (ar_a == 32'd50) begin
            m_rdata = 32'hDEADBEEF; m_rresp = 2'b10;
          end else begin
            m_rdata = mem[ar_a[5:2]]; m_rresp = 2'b00;
          end
        end
      end
      m_wready = (w_dly_cfg == 0) || (aw_got && wcount >= w_dly_cfg);
    end
  end

  task automatic issue(input logic idx, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    req[idx]    = 1'b1;
    req_we[idx] = we;
    if (idx) begin
      req_addr[63:32] = addr; req_wdata[63:32] = data; req_wstrb[7:4] = strb;
    end else begin
      req_addr[31:0] = addr; req_wdata[31:0] = data; req_wstrb[3:0] = strb;
    end
  endtask

  task automatic wait_done(input string tag, input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == 2'b00 && cyc < bound);
    check_eq({tag, "_seen"}, {63'd0, done != 2'b00}, 64'd1);
  endtask

  initial begin
    int cyc;
    int aw0, w0;
    reset = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_done",   done, 0);
    check_eq("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    check_eq("rst_rdata",  rsp_rdata, 0);
    check_eq("rst_resp",   rsp_resp, 0);
    check_eq("rst_awaddr", m_awaddr, 0);
    reset = 1'b1;

    // Write addr 0, zero-wait slave
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF);
    @(negedge clk);
    check_eq("wr_t1_valids", {m_awvalid, m_wvalid, m_bready}, 3'b110);
    check_eq("wr_t1_wdata",  {m_awaddr, m_wdata}, {32'h0, 32'h12345678});
    check_eq("wr_t1_wstrb",  m_wstrb, 4'hF);
    @(negedge clk);
    check_eq("wr_t2_valids", {m_awvalid, m_wvalid, m_bready, done}, 5'b00100);
    @(negedge clk);
    check_eq("wr_t3_done", done, 2'b01);
    check_eq("wr_t3_resp", {rsp_resp, rsp_rdata}, 34'h0);
    req = '0;
    check_eq("wr_hs_count", {aw_cnt[7:0], w_cnt[7:0]}, 16'h0101);
    @(negedge clk);
    check_eq("wr_t4_done", done, 2'b00);

    // Read addr 0
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("rd_t1", {m_arvalid, m_rready, m_awvalid}, 3'b100);
    check_eq("rd_t1_araddr", m_araddr, 32'h0);
    @(negedge clk);
    check_eq("rd_t2", {m_arvalid, m_rready, done}, 4'b0100);
    @(negedge clk);
    check_eq("rd_t3_done",  done, 2'b01);
    check_eq("rd_t3_rdata", rsp_rdata, 32'h12345678);
    check_eq("rd_t3_resp",  rsp_resp, 2'b00);
    req = '0;

    // W ready held off 3 cycles after AW handshake, requester 1
    w_dly_cfg = 3;
    aw0 = aw_cnt; w0 = w_cnt;
    @(negedge clk);
    issue(1'b1, 1'b1, 32'h4, 32'hA5A50F0F, 4'b0011);
    @(negedge clk);
    check_eq("dly_t1", {m_awvalid, m_wvalid, m_bready}, 3'b110);
    check_eq("dly_t1_addr", {m_awaddr, m_wstrb}, {32'h4, 4'b0011});
    @(negedge clk);
    check_eq("dly_t2", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    @(negedge clk);
    check_eq("dly_t3", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    @(negedge clk);
    check_eq("dly_t4", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    check_eq("dly_t4_wdata", m_wdata, 32'hA5A50F0F);
    @(negedge clk);
    check_eq("dly_t5", {m_awvalid, m_wvalid, m_bready, done}, 5'b00100);
    @(negedge clk);
    check_eq("dly_t6_done", {done, rsp_resp}, {2'b10, 2'b00});
    req = '0;
    w_dly_cfg = 0;
    check_eq("dly_hs_count", {aw_cnt - aw0, w_cnt - w0}, {32'd1, 32'd1});

    // Read back requester 1 addr 4: only the low two bytes were strobed
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    wait_done("rd4", 10, cyc);
    check_eq("rd4_lat",   cyc, 3);
    check_eq("rd4_done",  done, 2'b10);
    check_eq("rd4_rdata", rsp_rdata, 32'h00000F0F);
    req = '0;

    // Error responses at addr 50
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd50, 32'h1, 4'hF);
    wait_done("werr", 10, cyc);
    check_eq("werr_lat",  cyc, 3);
    check_eq("werr_resp", {done, rsp_resp, rsp_rdata}, {2'b01, 2'b10, 32'h0});
    req = '0;
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd50, 32'h0, 4'h0);
    wait_done("rerr", 10, cyc);
    check_eq("rerr_resp", {done, rsp_resp, rsp_rdata}, {2'b01, 2'b10, 32'hDEADBEEF});
    req = '0;

    // Reset while waiting in the read-data phase
    r_hold = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("rrst_t1", m_arvalid, 1'b1);
    @(negedge clk);
    check_eq("rrst_t2", {m_arvalid, m_rready}, 2'b01);
    reset = 1'b0;
    #1;
    check_eq("rrst_outs", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, done}, 0);
    check_eq("rrst_rsp",  {rsp_resp, rsp_rdata}, 34'h0);
    req = '0;
    r_hold = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rrst_idle", {m_arvalid, m_rready, done}, 0);

    // Both requesting continuously: 0 write addr 8, 1 read addr 0
    req_we    = 2'b01;
    req_addr  = {32'h0, 32'h8};
    req_wdata = {32'h0, 32'hCAFEF00D};
    req_wstrb = {4'h0, 4'hF};
    req       = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done($sformatf("arb%0d", k), 10, cyc);
      check_eq($sformatf("arb%0d_done", k), done, (k % 2 == 0) ? 2'b01 : 2'b10);
      check_eq($sformatf("arb%0d_lat", k), cyc, (k == 0) ? 3 : 4);
      check_eq($sformatf("arb%0d_rdata", k), rsp_rdata, (k % 2 == 0) ? 32'h0 : 32'h12345678);
    end
    req = '0;
    @(negedge clk);
    check_eq("arb_end_done", done, 2'b00);

    // Data written during arbitration is readable
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
    wait_done("rd8", 10, cyc);
    check_eq("rd8_rdata", {done, rsp_rdata}, {2'b01, 32'hCAFEF00D});
    req = '0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before 100000 time units");
    $fatal(1);
  end

endmodule
